// File: rtl/gauss_sequencer_pkg.sv
// Shared FSM encoding and datapath control words for the n(n+1)/2 sequencer.
package gauss_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StCheck,
    StAcc,
    StDec,
    StResp
  } state_e;

  // Control word bit order is {dec_n, load_acum, init}.
  localparam logic [2:0] CW_NOP  = 3'b000;
  localparam logic [2:0] CW_INIT = 3'b001;
  localparam logic [2:0] CW_ACC  = 3'b010;
  localparam logic [2:0] CW_DEC  = 3'b100;

endpackage

// File: rtl/gauss_datapath.sv
// Datapath: counts n down to zero while accumulating n into the result.
module gauss_datapath import gauss_sequencer_pkg::*; #(
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             preset,
  input  logic [2:0]       ctrlword,
  input  logic [width-1:0] data_in,
  output logic             status,
  output logic             prediction,
  output logic             done,
  output logic [width-1:0] result
);

  logic [width-1:0] n_q;
  logic [width-1:0] acc_q;
  logic             pred_q;

  // Load, accumulate or decrement as commanded; pred_q remembers an n==1 accumulate.
  always_ff @(posedge clk) begin
    if (preset) begin
      n_q    <= '0;
      acc_q  <= '0;
      pred_q <= 1'b0;
    end else if (ctrlword == CW_INIT) begin
      n_q    <= data_in;
      acc_q  <= '0;
      pred_q <= 1'b0;
    end else if (ctrlword == CW_ACC) begin
      acc_q  <= acc_q + n_q;
      pred_q <= (n_q == width'(1));
    end else if (ctrlword == CW_DEC) begin
      n_q    <= n_q - width'(1);
    end
  end

  // Flags and result are straight views of the registers.
  always_comb begin
    status     = (n_q != '0);
    done       = (n_q == '0);
    prediction = pred_q;
    result     = acc_q;
  end

endmodule

// File: rtl/gauss_unit_top.sv
// Wrapper pairing the sequencer with its datapath.
module gauss_unit_top #(
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             start,
  input  logic [width-1:0] operand,
  output logic             start_ready,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [width-1:0] result_out,
  output logic [width-1:0] iter_count,
  output logic             error
);

  logic [2:0]       ctrlword;
  logic [width-1:0] data;
  logic             status;
  logic             prediction;
  logic             done;
  logic [width-1:0] result;

  gauss_sequencer #(.width(width)) u_seq (
    .clk          (clk),
    .preset       (preset),
    .start        (start),
    .operand      (operand),
    .start_ready  (start_ready),
    .ctrlword     (ctrlword),
    .data_out     (data),
    .status_i     (status),
    .prediction_i (prediction),
    .done_i       (done),
    .result_i     (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_out   (result_out),
    .iter_count   (iter_count),
    .error        (error)
  );

  gauss_datapath #(.width(width)) u_dp (
    .clk        (clk),
    .preset     (preset),
    .ctrlword   (ctrlword),
    .data_in    (data),
    .status     (status),
    .prediction (prediction),
    .done       (done),
    .result     (result)
  );

endmodule

// File: rtl/gauss_sequencer.sv
// Control FSM that drives the gauss datapath and hands the result back.
module gauss_sequencer import gauss_sequencer_pkg::*; #(
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             start,
  input  logic [width-1:0] operand,
  output logic             start_ready,
  output logic [2:0]       ctrlword,
  output logic [width-1:0] data_out,
  input  logic             status_i,
  input  logic             prediction_i,
  input  logic             done_i,
  input  logic [width-1:0] result_i,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [width-1:0] result_out,
  output logic [width-1:0] iter_count,
  output logic             error
);

  state_e           state_q, state_d;
  logic [width-1:0] data_q;
  logic [width-1:0] iter_q;
  logic [width-1:0] result_q;
  logic             error_q;

  // State register and job bookkeeping.
  always_ff @(posedge clk) begin
    if (preset) begin
      state_q  <= StIdle;
      data_q   <= '0;
      iter_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        data_q <= operand;
        iter_q <= '0;
      end
      if (state_q == StAcc) begin
        iter_q <= iter_q + width'(1);
      end
      // Capture only on the entering edge so the result holds while waiting for ready.
      if (state_d == StResp && state_q != StResp) begin
        result_q <= result_i;
      end
      // Sticky: flags that disagree with the datapath's count.
      if ((state_q == StAcc && !status_i) || (state_q == StCheck && status_i && done_i)) begin
        error_q <= 1'b1;
      end
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_d      = state_q;
    ctrlword     = CW_NOP;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      StIdle: begin
        start_ready = 1'b1;
        if (start) state_d = StInit;
      end
      StInit: begin
        ctrlword = CW_INIT;
        state_d  = StCheck;
      end
      StCheck: begin
        state_d = done_i ? StResp : StAcc;
      end
      StAcc: begin
        ctrlword = CW_ACC;
        state_d  = StDec;
      end
      StDec: begin
        ctrlword = CW_DEC;
        state_d  = prediction_i ? StResp : StAcc;
      end
      StResp: begin
        result_valid = 1'b1;
        if (result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign data_out   = data_q;
  assign iter_count = iter_q;
  assign result_out = result_q;
  assign error      = error_q;

endmodule

// File: tb/tb_gauss_sequencer.sv
// Directed bench for gauss_sequencer, paired with the datapath at widths 16 and 8.
module tb_gauss_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // width 16 instance
  logic        preset, start, result_ready, force_lo, force_hi;
  logic [15:0] operand;
  logic        start_ready, result_valid, error;
  logic [2:0]  ctrlword;
  logic [15:0] data_out, result_out, iter_count;
  logic        dp_status, dp_pred, dp_done, status_mux;
  logic [15:0] dp_result;

  // width 8 instance
  logic        start8, result_ready8;
  logic [7:0]  operand8;
  logic        start_ready8, result_valid8, error8;
  logic [2:0]  ctrlword8;
  logic [7:0]  data_out8, result_out8, iter_count8;
  logic        dp_status8, dp_pred8, dp_done8;
  logic [7:0]  dp_result8;

  int   total = 0;
  int   bad   = 0;
  logic seen_rv;
  logic [2:0] seq4 [10];

  assign status_mux = force_lo ? 1'b0 : (force_hi ? 1'b1 : dp_status);

  gauss_sequencer #(.width(16)) u_dut (
    .clk(clk), .preset(preset), .start(start), .operand(operand),
    .start_ready(start_ready), .ctrlword(ctrlword), .data_out(data_out),
    .status_i(status_mux), .prediction_i(dp_pred), .done_i(dp_done), .result_i(dp_result),
    .result_valid(result_valid), .result_ready(result_ready), .result_out(result_out),
    .iter_count(iter_count), .error(error)
  );

  gauss_datapath #(.width(16)) u_dp (
    .clk(clk), .preset(preset), .ctrlword(ctrlword), .data_in(data_out),
    .status(dp_status), .prediction(dp_pred), .done(dp_done), .result(dp_result)
  );

  gauss_sequencer #(.width(8)) u_dut8 (
    .clk(clk), .preset(preset), .start(start8), .operand(operand8),
    .start_ready(start_ready8), .ctrlword(ctrlword8), .data_out(data_out8),
    .status_i(dp_status8), .prediction_i(dp_pred8), .done_i(dp_done8), .result_i(dp_result8),
    .result_valid(result_valid8), .result_ready(result_ready8), .result_out(result_out8),
    .iter_count(iter_count8), .error(error8)
  );

  gauss_datapath #(.width(8)) u_dp8 (
    .clk(clk), .preset(preset), .ctrlword(ctrlword8), .data_in(data_out8),
    .status(dp_status8), .prediction(dp_pred8), .done(dp_done8), .result(dp_result8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    seq4 = '{3'b001, 3'b000, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100};
    preset = 1'b1; start = 1'b0; operand = '0; result_ready = 1'b1;
    force_lo = 1'b0; force_hi = 1'b0;
    start8 = 1'b0; operand8 = '0; result_ready8 = 1'b1;
    step(); step();
    preset = 1'b0;

    // Reset state
    check("rst_start_ready", start_ready, 1);
    check("rst_ctrlword", ctrlword, 0);
    check("rst_data_out", data_out, 0);
    check("rst_result_out", result_out, 0);
    check("rst_iter_count", iter_count, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_error", error, 0);
    check("rst_start_ready8", start_ready8, 1);

    // operand=4: 10-cycle latency, result 10, ctrlword sequence
    operand = 16'd4; start = 1'b1;
    step();
    start = 1'b0; operand = 16'h55;
    seen_rv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("n4_ctrlword", ctrlword, seq4[k]);
      check("n4_data_out", data_out, 4);
      seen_rv = seen_rv | result_valid;
      step();
    end
    check("n4_early_valid", seen_rv, 0);
    check("n4_result_valid", result_valid, 1);
    check("n4_result_out", result_out, 10);
    check("n4_iter_count", iter_count, 4);
    step();
    check("n4_back_idle", start_ready, 1);
    check("n4_valid_drop", result_valid, 0);
    check("n4_result_hold", result_out, 10);

    // operand=0: RESP two cycles after accept
    operand = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("n0_init_cw", ctrlword, 3'b001);
    step();
    check("n0_check_cw", ctrlword, 3'b000);
    check("n0_check_valid", result_valid, 0);
    step();
    check("n0_result_valid", result_valid, 1);
    check("n0_result_out", result_out, 0);
    check("n0_iter_count", iter_count, 0);
    step();
    check("n0_back_idle", start_ready, 1);

    // operand=1 with stalled consumer; start pulses ignored in RESP
    operand = 16'd1; start = 1'b1; result_ready = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("n1_result_valid", result_valid, 1);
    check("n1_result_out", result_out, 1);
    check("n1_iter_count", iter_count, 1);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0); operand = 16'd9;
      step();
      check("n1_stall_valid", result_valid, 1);
      check("n1_stall_result", result_out, 1);
      check("n1_stall_data", data_out, 1);
    end
    // ready and start together: only RESP->IDLE
    start = 1'b1; result_ready = 1'b1;
    step();
    start = 1'b0;
    check("n1_idle_ready", start_ready, 1);
    check("n1_idle_cw", ctrlword, 0);
    check("n1_idle_valid", result_valid, 0);
    check("n1_not_resampled", data_out, 1);
    step();
    check("n1_start_dropped", start_ready, 1);

    // operand=6 aborted by preset in the 5th ACC cycle, then operand=3
    operand = 16'd6; start = 1'b1;
    step();
    start = 1'b0;
    seen_rv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      seen_rv = seen_rv | result_valid;
      step();
    end
    check("n6_in_acc", ctrlword, 3'b010);
    check("n6_iter_before", iter_count, 4);
    preset = 1'b1;
    step();
    preset = 1'b0;
    check("abort_cw", ctrlword, 0);
    check("abort_idle", start_ready, 1);
    check("abort_data_out", data_out, 0);
    check("abort_iter", iter_count, 0);
    check("abort_result_out", result_out, 0);
    check("abort_valid", result_valid, 0);
    check("abort_never_valid", seen_rv, 0);
    operand = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    seen_rv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      seen_rv = seen_rv | result_valid;
      step();
    end
    check("n3_early_valid", seen_rv, 0);
    check("n3_result_valid", result_valid, 1);
    check("n3_result_out", result_out, 6);
    check("n3_iter_count", iter_count, 3);
    step();

    // width=8, operand=255: result wraps to 128
    operand8 = 8'd255; start8 = 1'b1;
    step();
    start8 = 1'b0;
    seen_rv = 1'b0;
    for (int k = 0; k < 512; k++) begin
      seen_rv = seen_rv | result_valid8;
      step();
    end
    check("w8_early_valid", seen_rv, 0);
    check("w8_result_valid", result_valid8, 1);
    check("w8_result_out", result_out8, 128);
    check("w8_iter_count", iter_count8, 255);
    step();
    check("w8_back_idle", start_ready8, 1);

    // status_i forced low during ACC: sticky error, FSM carries on
    check("err_clear_before", error, 0);
    operand = 16'd2; start = 1'b1; force_lo = 1'b1;
    step();
    start = 1'b0;
    step();
    check("err_in_check", error, 0);
    step();
    check("err_during_acc", error, 0);
    step();
    check("err_set", error, 1);
    for (int k = 0; k < 3; k++) step();
    check("err_job_valid", result_valid, 1);
    check("err_job_result", result_out, 3);
    check("err_held_resp", error, 1);
    step();
    force_lo = 1'b0;
    check("err_held_idle", error, 1);
    operand = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("err_clean_job", result_out, 1);
    check("err_still_set", error, 1);
    step();
    preset = 1'b1;
    step();
    preset = 1'b0;
    check("err_cleared", error, 0);

    // status_i high with done_i in CHECK
    operand = 16'd0; start = 1'b1; force_hi = 1'b1;
    step();
    start = 1'b0;
    check("errc_init", error, 0);
    step();
    check("errc_in_check", error, 0);
    step();
    check("errc_set", error, 1);
    check("errc_valid", result_valid, 1);
    step();
    force_hi = 1'b0;
    preset = 1'b1;
    step();
    preset = 1'b0;
    check("errc_cleared", error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gauss_sequencer.md
GAUSS_SEQUENCER -- requirements
Module: gauss_sequencer

Interface
REQ-001 Parameter: width, default 16, operand/result width; SHALL match the attached datapath.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 preset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request valid; operand accepted when start & start_ready.
REQ-005 operand  input  width  value n for the n(n+1)/2 computation.
REQ-006 start_ready  output  1  high only in IDLE.
REQ-007 ctrlword  output  3  datapath control {dec_n, load_acum, init}; one-hot or zero.
REQ-008 data_out  output  width  operand register, drives datapath data input.
REQ-009 status_i  input  1  datapath busy flag (n>0).
REQ-010 prediction_i  input  1  datapath registered flag: the last accumulate used n==1.
REQ-011 done_i  input  1  datapath flag (n==0).
REQ-012 result_i  input  width  datapath accumulator.
REQ-013 result_valid  output  1  result available.
REQ-014 result_ready  input  1  consumer accepts result.
REQ-015 result_out  output  width  captured result.
REQ-016 iter_count  output  width  number of accumulate steps issued for the current job.
REQ-017 error  output  1  sticky protocol error, cleared only by preset.

Function
REQ-018 FSM states: IDLE, INIT, CHECK, ACC, DEC, RESP.
REQ-019 Per-state ctrlword:
- INIT=001
- ACC=010
- DEC=100
- all other states=000
REQ-020 IDLE: on start, latch operand into data_out, clear iter_count, go INIT; otherwise stay.
REQ-021 INIT lasts exactly one cycle, then CHECK.
REQ-022 CHECK transitions: done_i=1 -> RESP; otherwise ACC.
REQ-023 ACC lasts one cycle, increments iter_count (mod 2^width), then DEC.
REQ-024 DEC transitions: prediction_i=1 -> RESP; otherwise ACC.
REQ-025 Result capture: on entry to RESP, result_out <= result_i; result_out SHALL hold until the next RESP entry.
REQ-026 RESP handshake:
- result_valid=1 while in RESP.
- result_ready=1 -> IDLE next cycle.
- result_valid SHALL stay high until accepted.
REQ-027 Latency:
- RESP is entered 2N+2 cycles after the accepting edge, for operand N (N=0 gives 2).
- iter_count=N at RESP.
REQ-028 Arithmetic: result is modulo 2^width; no overflow flag.
REQ-029 start outside IDLE SHALL be ignored; operand is not re-sampled.
REQ-030 error SHALL set if either of these holds:
- status_i=0 during ACC;
- status_i=1 in CHECK with done_i=1.
The FSM SHALL continue normally after setting error.
REQ-031 Simultaneous result_ready and start in RESP: RESP->IDLE only; the start is not accepted that cycle.
REQ-032 data_out SHALL remain stable from INIT through RESP.

Reset
REQ-033 preset SHALL force, at the next edge, regardless of state:
- state=IDLE;
- ctrlword=000;
- data_out=0, result_out=0, iter_count=0;
- result_valid=0, error=0;
- start_ready=1.
REQ-034 preset mid-job SHALL abandon the job without emitting result_valid; the datapath shares preset.

Structure
REQ-035 The shared package SHALL hold:
- the FSM state encoding;
- the ctrlword constants CW_NOP=000, CW_INIT=001, CW_ACC=010, CW_DEC=100.
REQ-036 Sub-module: one test-level wrapper, gauss_unit_top, SHALL instantiate gauss_sequencer plus the existing datapath; the sequencer itself is flat.

Verification
REQ-037 operand=4, start one cycle, result_ready=1 -> result_valid 10 cycles after accept; result_out=10; iter_count=4; ctrlword sequence 001,000,(010,100)x4.
REQ-038 operand=0 -> RESP 2 cycles after accept; result_out=0; iter_count=0; no 010/100 issued.
REQ-039 operand=1, result_ready held low 5 cycles -> result_valid=1 and result_out=1 stable throughout; start pulses ignored; IDLE after ready.
REQ-040 operand=6, preset asserted in the 5th ACC-phase cycle -> next cycle IDLE, ctrlword=000, result_valid never asserted; a following operand=3 job yields 6.
REQ-041 width=8, operand=255 -> result_out=(255*256/2) mod 256=128, iter_count=255.
REQ-042 Stub datapath forcing status_i=0 during ACC -> error=1 and stays set until preset.
